// File: rtl/time_pkg.sv
// Shared types and constants for the time-setting path: edit states, field
// encodings, field widths and wrap-around increment helpers.
package time_pkg;

  localparam int H_W = 5;
  localparam int M_W = 6;
  localparam int S_W = 6;

  localparam logic [H_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [M_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [S_W-1:0] SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_IDLE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  function automatic logic [H_W-1:0] inc_hour(input logic [H_W-1:0] v);
    return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_sixty(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push-button;
// emits the accepted level and a one-cycle pulse on its rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The counter only advances while the sample disagrees with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time editor: debounces mode/inc, walks hours/minutes/seconds,
// auto-repeats held increments and strobes load with the edited time.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_mode,
  input  logic           btn_inc,
  input  logic [H_W-1:0] cur_h,
  input  logic [M_W-1:0] cur_m,
  input  logic [S_W-1:0] cur_s,
  output logic [H_W-1:0] set_h,
  output logic [M_W-1:0] set_m,
  output logic [S_W-1:0] set_s,
  output logic           load,
  output logic [1:0]     edit_field
);

  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = $clog2(RPT_MAX) + 1;

  state_t         state, state_n;
  logic [H_W-1:0] h_n;
  logic [M_W-1:0] m_n;
  logic [S_W-1:0] s_n;
  logic           load_n;
  logic [CW-1:0]  rep_cnt, rep_cnt_n;
  logic           rep_act, rep_act_n;
  logic           inc_fire;
  logic           mode_press, mode_level;
  logic           inc_press, inc_level;
  logic           unused_mode_level;

  assign unused_mode_level = mode_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .level(mode_level), .press(mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .level(inc_level), .press(inc_press)
  );

  // State, shadow time, load strobe and repeat timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      set_h   <= '0;
      set_m   <= '0;
      set_s   <= '0;
      load    <= 1'b0;
      rep_cnt <= '0;
      rep_act <= 1'b0;
    end else begin
      state   <= state_n;
      set_h   <= h_n;
      set_m   <= m_n;
      set_s   <= s_n;
      load    <= load_n;
      rep_cnt <= rep_cnt_n;
      rep_act <= rep_act_n;
    end
  end

  // Mode transitions take priority; an inc event in the same cycle is dropped
  // because the state change also clears the repeat logic.
  always_comb begin
    state_n   = state;
    h_n       = set_h;
    m_n       = set_m;
    s_n       = set_s;
    load_n    = 1'b0;
    rep_cnt_n = rep_cnt;
    rep_act_n = rep_act;
    inc_fire  = 1'b0;

    case (state)
      IDLE: begin
        if (mode_press) begin
          h_n     = cur_h;
          m_n     = cur_m;
          s_n     = cur_s;
          state_n = EDIT_H;
        end
      end
      EDIT_H:  if (mode_press) state_n = EDIT_M;
      EDIT_M:  if (mode_press) state_n = EDIT_S;
      EDIT_S: begin
        if (mode_press) begin
          load_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state || state == IDLE || !inc_level) begin
      rep_cnt_n = '0;
      rep_act_n = 1'b0;
    end else if (inc_press) begin
      rep_cnt_n = '0;
      rep_act_n = 1'b0;
      inc_fire  = 1'b1;
    end else if (!rep_act) begin
      if (rep_cnt == CW'(HOLD_CYCLES - 1)) begin
        rep_cnt_n = '0;
        rep_act_n = 1'b1;
        inc_fire  = 1'b1;
      end else begin
        rep_cnt_n = rep_cnt + CW'(1);
      end
    end else if (rep_cnt == CW'(REPEAT_CYCLES - 1)) begin
      rep_cnt_n = '0;
      inc_fire  = 1'b1;
    end else begin
      rep_cnt_n = rep_cnt + CW'(1);
    end

    if (inc_fire) begin
      case (state)
        EDIT_H:  h_n = inc_hour(set_h);
        EDIT_M:  m_n = inc_sixty(set_m, MIN_MAX);
        EDIT_S:  s_n = inc_sixty(set_s, SEC_MAX);
        default: h_n = set_h;
      endcase
    end
  end

  assign edit_field = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl with short debounce/hold/repeat timings.
module tb_time_set_ctrl;

  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_h, set_h;
  logic [5:0] cur_m, cur_s, set_m, set_s;
  logic       load;
  logic [1:0] edit_field;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] f;
    logic       l;
  } snap_t;

  snap_t exp_q[$];
  snap_t prev_s, now_s, exp_s;
  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;

  always #5 clk = ~clk;

  time_set_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .set_h(set_h), .set_m(set_m), .set_s(set_s),
    .load(load), .edit_field(edit_field)
  );

  // Every visible output change must match the next queued expectation.
  always @(negedge clk) begin
    now_s = '{set_h, set_m, set_s, edit_field, load};
    if (mon_en && now_s != prev_s) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %0d:%0d:%0d field %0d load %0d, required no change",
                 now_s.h, now_s.m, now_s.s, now_s.f, now_s.l);
      end else begin
        exp_s = exp_q.pop_front();
        if (now_s !== exp_s) begin
          fails++;
          $display("FAIL sb_update: got %0d:%0d:%0d field %0d load %0d, required %0d:%0d:%0d field %0d load %0d",
                   now_s.h, now_s.m, now_s.s, now_s.f, now_s.l,
                   exp_s.h, exp_s.m, exp_s.s, exp_s.f, exp_s.l);
        end
      end
    end
    prev_s = now_s;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int h, input int m, input int s, input int f, input int l);
    snap_t e;
    e.h = 5'(h); e.m = 6'(m); e.s = 6'(s); e.f = 2'(f); e.l = 1'(l);
    exp_q.push_back(e);
  endtask

  task automatic press(input bit m, input bit i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    tick(hold);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(12);
  endtask

  task automatic test_reset;
    bit bad;
    cur_h = 5'd5; cur_m = 6'd6; cur_s = 6'd7;
    push(5, 6, 7, 1, 0);
    press(1'b1, 1'b0, 10);
    #2 mon_en = 1'b0; rst = 1'b1;
    #1;
    tests++;
    if ({set_h, set_m, set_s, edit_field, load} !== 20'd0) begin
      fails++;
      $display("FAIL reset_async: got %0d:%0d:%0d field %0d load %0d, required all 0",
               set_h, set_m, set_s, edit_field, load);
    end
    #3 rst = 1'b0; mon_en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (load !== 1'b0 || edit_field !== 2'd0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_idle: got load/field activity, required load 0 and field 0");
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL reset_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mode_cycle;
    cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;
    push(12, 34, 56, 1, 0);
    btn_mode = 1'b1;
    tick(6);
    tests++;
    if (edit_field !== 2'd0) begin
      fails++;
      $display("FAIL mode_early: got field %0d after 6 edges, required 0", edit_field);
    end
    tick(1);
    tests++;
    if (edit_field !== 2'd1 || set_h !== 5'd12 || set_m !== 6'd34 || set_s !== 6'd56) begin
      fails++;
      $display("FAIL mode_latency: got field %0d %0d:%0d:%0d after 7 edges, required 1 12:34:56",
               edit_field, set_h, set_m, set_s);
    end
    tick(3);
    btn_mode = 1'b0;
    tick(12);
    cur_h = 5'd1; cur_m = 6'd2; cur_s = 6'd3;
    push(12, 34, 56, 2, 0);
    press(1'b1, 1'b0, 10);
    push(12, 34, 56, 3, 0);
    press(1'b1, 1'b0, 10);
    push(12, 34, 56, 0, 1);
    push(12, 34, 56, 0, 0);
    press(1'b1, 1'b0, 10);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL mode_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap;
    cur_h = 5'd22; cur_m = 6'd58; cur_s = 6'd0;
    push(22, 58, 0, 1, 0); press(1'b1, 1'b0, 10);
    push(23, 58, 0, 1, 0); press(1'b0, 1'b1, 10);
    push(0, 58, 0, 1, 0);  press(1'b0, 1'b1, 10);
    push(0, 58, 0, 2, 0);  press(1'b1, 1'b0, 10);
    push(0, 59, 0, 2, 0);  press(1'b0, 1'b1, 10);
    push(0, 0, 0, 2, 0);   press(1'b0, 1'b1, 10);
    push(0, 0, 0, 3, 0);   press(1'b1, 1'b0, 10);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 5; i++) begin
      btn_inc = 1'b1; tick(2);
      btn_inc = 1'b0; tick(2);
    end
    push(0, 0, 1, 3, 0);
    btn_inc = 1'b1; tick(8);
    btn_inc = 1'b0; tick(12);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL bounce_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_auto_repeat;
    push(0, 0, 1, 0, 1); push(0, 0, 1, 0, 0);
    press(1'b1, 1'b0, 10);
    cur_h = 5'd10; cur_m = 6'd20; cur_s = 6'd0;
    push(10, 20, 0, 1, 0); press(1'b1, 1'b0, 10);
    push(10, 20, 0, 2, 0); press(1'b1, 1'b0, 10);
    push(10, 20, 0, 3, 0); press(1'b1, 1'b0, 10);
    for (int v = 1; v <= 6; v++) push(10, 20, v, 3, 0);
    btn_inc = 1'b1;
    tick(7);
    tests++;
    if (set_s !== 6'd1) begin
      fails++;
      $display("FAIL repeat_first: got set_s %0d, required 1", set_s);
    end
    tick(15);
    tests++;
    if (set_s !== 6'd1) begin
      fails++;
      $display("FAIL repeat_hold: got set_s %0d before hold expiry, required 1", set_s);
    end
    tick(1);
    tests++;
    if (set_s !== 6'd2) begin
      fails++;
      $display("FAIL repeat_second: got set_s %0d, required 2", set_s);
    end
    tick(13);
    btn_inc = 1'b0;
    tick(30);
    tests++;
    if (set_s !== 6'd6) begin
      fails++;
      $display("FAIL repeat_final: got set_s %0d, required 6", set_s);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL repeat_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous;
    bit bad;
    push(10, 20, 6, 0, 1); push(10, 20, 6, 0, 0);
    press(1'b1, 1'b0, 10);
    cur_h = 5'd1; cur_m = 6'd2; cur_s = 6'd3;
    push(1, 2, 3, 1, 0); press(1'b1, 1'b0, 10);
    push(1, 2, 3, 2, 0); press(1'b1, 1'b0, 10);
    push(1, 2, 3, 3, 0); press(1'b1, 1'b1, 10);
    tests++;
    if (set_m !== 6'd2 || edit_field !== 2'd3) begin
      fails++;
      $display("FAIL simul_mode_wins: got set_m %0d field %0d, required 2 and 3", set_m, edit_field);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL simul_drain: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    #2 mon_en = 1'b0; rst = 1'b1;
    #1;
    tests++;
    if ({set_h, set_m, set_s, edit_field, load} !== 20'd0) begin
      fails++;
      $display("FAIL reset_edit_s: got %0d:%0d:%0d field %0d load %0d, required all 0",
               set_h, set_m, set_s, edit_field, load);
    end
    #3 rst = 1'b0; mon_en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (load !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_no_load: got load pulse after mid-edit reset, required none");
    end
  endtask

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_h = 5'd0; cur_m = 6'd0; cur_s = 6'd0;
    tick(3);
    rst = 1'b0;
    tick(2);
    mon_en = 1'b1;
    test_reset();
    test_mode_cycle();
    test_wrap();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
